ad_capture_ctrl: RTL
====================

AD_CAPTURE_CTRL -- requirements
Module: ad_capture_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 12, capture buffer address width.
REQ-002 Parameter: DATA_W, default 8, AD sample width.
REQ-003 Port: clk  in  1  single system clock; all logic on rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: addata  in  DATA_W  AD data, one sample per clk.
REQ-006 Port: cmd_start  in  1  Internet Ctrl capture request pulse.
REQ-007 Port: cmd_abort  in  1  Internet Ctrl abort pulse.
REQ-008 Port: net_ack  in  1  Internet Ctrl has read the buffer; releases DONE.
REQ-009 Port: cfg_len  in  ADDR_W  samples to capture; 0 means 2^ADDR_W.
REQ-010 Port: cfg_decim  in  4  keep one sample in every cfg_decim+1.
REQ-011 Port: cfg_thresh  in  DATA_W  unsigned trigger level.
REQ-012 Port: buf_we  out  1  buffer write strobe.
REQ-013 Port: buf_waddr  out  ADDR_W  buffer write address.
REQ-014 Port: buf_wdata  out  DATA_W  buffer write data.
REQ-015 Port: busy  out  1  high in ARM or CAPTURE.
REQ-016 Port: done  out  1  capture complete; high in DONE.
REQ-017 Port: wr_count  out  ADDR_W+1  samples written in current or last capture.

Function
REQ-018 The block SHALL implement the states IDLE, ARM, CAPTURE and DONE.
REQ-019 The block SHALL register addata into ad_q every cycle and ad_q into ad_q2.
REQ-020 In IDLE, cmd_start SHALL latch cfg_len, cfg_decim and cfg_thresh, clear wr_count and move to ARM.
REQ-021 In ARM, a trigger (ad_q2 < thresh and ad_q >= thresh, unsigned) SHALL move to CAPTURE.
REQ-022 In CAPTURE, on every (decim+1)th cycle counting from the first CAPTURE cycle, the block SHALL write ad_q with buf_we=1, buf_waddr=wr_count[ADDR_W-1:0], and increment wr_count.
REQ-023 The buffer outputs SHALL be registered: buf_we, buf_waddr and buf_wdata become valid one cycle after the decision cycle; buf_we is otherwise 0.
REQ-024 After the write that makes wr_count equal the latched length (2^ADDR_W when cfg_len=0), the block SHALL enter DONE with no further writes.
REQ-025 In DONE, done SHALL stay high until net_ack, then return to IDLE; wr_count SHALL hold.
REQ-026 cmd_start outside IDLE SHALL be ignored; cfg_* changes outside IDLE SHALL have no effect.
REQ-027 cmd_abort in ARM, CAPTURE or DONE SHALL force IDLE on the next edge, suppress further writes, and keep wr_count.
REQ-028 If cmd_abort and cmd_start are both high in IDLE, abort SHALL win and the block stays in IDLE.
REQ-029 If cmd_abort and net_ack are both high in DONE, the block SHALL go to IDLE.
REQ-030 The waddr increment SHALL not wrap within one capture; wr_count reaches 2^ADDR_W exactly on the full-depth end.

Reset
REQ-031 With rst_n low the block SHALL enter IDLE and clear buf_we, buf_waddr, buf_wdata, busy, done, wr_count, ad_q, ad_q2 and all latched cfg.
REQ-032 Reset during CAPTURE SHALL stop writes immediately, asynchronously.

Configuration
REQ-033 With AD_TRIG_EN defined, ARM SHALL wait for the trigger in REQ-021.
REQ-034 With AD_TRIG_EN undefined, ARM SHALL last exactly one cycle and then move to CAPTURE unconditionally; cfg_thresh is unused.

Verification
REQ-035 Trigger off, cfg_len=4, decim=0, addata ramp 0,1,2.. -> four consecutive buf_we, addresses 0..3, consecutive data, done=1, wr_count=4.
REQ-036 AD_TRIG_EN, thresh=0x80, addata 0x10,0x7F,0x80,.. -> first write data 0x80 at addr 0.
REQ-037 decim=2, cfg_len=3 -> buf_we every third cycle, three writes total, then DONE.
REQ-038 cmd_abort after 2 of 8 writes -> IDLE next edge, no third write, done=0, wr_count=2.
REQ-039 cfg_len=0, ADDR_W=4 -> 16 writes at addresses 0..15, wr_count=16, done until net_ack, then IDLE.

Source files
------------

// File: rtl/ad_capture_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ad_capture_ctrl                                            |
// | Description : AD sample capture controller. On a capture request from    |
// |               the Internet controller it arms, optionally waits for a    |
// |               rising threshold crossing, then writes a decimated run of  |
// |               samples into a capture buffer. It holds DONE until the     |
// |               buffer has been read.                                      |
// | Build option: AD_TRIG_EN - when defined, ARM waits for a rising crossing |
// |               of cfg_thresh. When undefined, ARM lasts one cycle and     |
// |               cfg_thresh is ignored.                                     |
// | Ports       : clk, rst_n        clock, asynchronous active-low reset     |
// |               addata            AD sample stream, one per clock          |
// |               cmd_start         capture request pulse (IDLE only)        |
// |               cmd_abort         abort pulse, returns to IDLE             |
// |               net_ack           buffer consumed, releases DONE           |
// |               cfg_len           capture length, 0 = 2^ADDR_W samples     |
// |               cfg_decim         keep one sample in every cfg_decim+1     |
// |               cfg_thresh        unsigned trigger level                   |
// |               buf_we/waddr/wdata registered capture buffer write port    |
// |               busy, done        status (ARM/CAPTURE, DONE)               |
// |               wr_count          samples written in current/last capture  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ad_capture_ctrl #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] addata,
   input  logic              cmd_start,
   input  logic              cmd_abort,
   input  logic              net_ack,
   input  logic [ADDR_W-1:0] cfg_len,
   input  logic [3:0]        cfg_decim,
   input  logic [DATA_W-1:0] cfg_thresh,
   output logic              buf_we,
   output logic [ADDR_W-1:0] buf_waddr,
   output logic [DATA_W-1:0] buf_wdata,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   wr_count
);

   // ------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------
   localparam logic [1:0] c_ST_IDLE    = 2'd0;
   localparam logic [1:0] c_ST_ARM     = 2'd1;
   localparam logic [1:0] c_ST_CAPTURE = 2'd2;
   localparam logic [1:0] c_ST_DONE    = 2'd3;

   // Full-depth length: cfg_len of zero selects 2^ADDR_W samples.
   localparam logic [ADDR_W:0] c_FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] c_CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   logic [1:0]        r_state;
   logic [1:0]        w_next_state;

   logic [DATA_W-1:0] r_ad_q;
   logic [DATA_W-1:0] r_ad_q2;

   logic [ADDR_W:0]   r_len;
   logic [3:0]        r_decim;
   logic [3:0]        r_decim_cnt;
   logic [ADDR_W:0]   r_wr_count;
   logic [ADDR_W:0]   w_count_inc;

   logic              r_buf_we;
   logic [ADDR_W-1:0] r_buf_waddr;
   logic [DATA_W-1:0] r_buf_wdata;

   logic              w_start;
   logic              w_trigger;
   logic              w_write;
   logic              w_last;
   logic              w_busy;
   logic              w_done;

   // ------------------------------------------------------------------
   // Sample pipeline: ad_q is the sample written, ad_q2 the one before
   // it, used for edge detection of the threshold crossing.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ad_q  <= '0;
         r_ad_q2 <= '0;
      end else begin
         r_ad_q  <= addata;
         r_ad_q2 <= r_ad_q;
      end
   end

   // A start request is accepted only in IDLE and only when no abort
   // arrives in the same cycle.
   assign w_start = (r_state == c_ST_IDLE) && cmd_start && !cmd_abort;

   // ------------------------------------------------------------------
   // Trigger qualification
   // ------------------------------------------------------------------
`ifdef AD_TRIG_EN
   logic [DATA_W-1:0] r_thresh;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_thresh <= '0;
      end else if (w_start) begin
         r_thresh <= cfg_thresh;
      end
   end

   // Rising crossing: previous sample below the level, current at/above.
   assign w_trigger = (r_ad_q2 < r_thresh) && (r_ad_q >= r_thresh);
`else
   logic w_unused_trig;

   // Without the trigger option ARM always advances after one cycle.
   assign w_trigger     = 1'b1;
   assign w_unused_trig = ^{cfg_thresh, r_ad_q2};
`endif

   // ------------------------------------------------------------------
   // Write decision. The decimation counter restarts at zero on the
   // first CAPTURE cycle, so that cycle always writes. An abort in the
   // same cycle suppresses the write.
   // ------------------------------------------------------------------
   assign w_count_inc = r_wr_count + c_CNT_ONE;
   assign w_write     = (r_state == c_ST_CAPTURE) && (r_decim_cnt == 4'd0) && !cmd_abort;
   assign w_last      = w_write && (w_count_inc == r_len);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic. Abort has priority everywhere.
   // ------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (w_start) begin
               w_next_state = c_ST_ARM;
            end
         end
         c_ST_ARM: begin
            if (cmd_abort) begin
               w_next_state = c_ST_IDLE;
            end else if (w_trigger) begin
               w_next_state = c_ST_CAPTURE;
            end
         end
         c_ST_CAPTURE: begin
            if (cmd_abort) begin
               w_next_state = c_ST_IDLE;
            end else if (w_last) begin
               w_next_state = c_ST_DONE;
            end
         end
         c_ST_DONE: begin
            if (cmd_abort || net_ack) begin
               w_next_state = c_ST_IDLE;
            end
         end
         default: begin
            w_next_state = c_ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: output logic
   // ------------------------------------------------------------------
   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         c_ST_ARM:     w_busy = 1'b1;
         c_ST_CAPTURE: w_busy = 1'b1;
         c_ST_DONE:    w_done = 1'b1;
         default: begin
            w_busy = 1'b0;
            w_done = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Configuration latched at start; later cfg_* changes are ignored.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len   <= '0;
         r_decim <= '0;
      end else if (w_start) begin
         r_len   <= (cfg_len == '0) ? c_FULL_LEN : {1'b0, cfg_len};
         r_decim <= cfg_decim;
      end
   end

   // ------------------------------------------------------------------
   // Decimation counter, active only in CAPTURE.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_decim_cnt <= '0;
      end else if (r_state != c_ST_CAPTURE) begin
         r_decim_cnt <= '0;
      end else if (r_decim_cnt == r_decim) begin
         r_decim_cnt <= '0;
      end else begin
         r_decim_cnt <= r_decim_cnt + 4'd1;
      end
   end

   // ------------------------------------------------------------------
   // Write counter: cleared at start, held across DONE and abort. It is
   // one bit wider than the address so a full-depth run ends at 2^ADDR_W
   // without wrapping.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_count <= '0;
      end else if (w_start) begin
         r_wr_count <= '0;
      end else if (w_write) begin
         r_wr_count <= w_count_inc;
      end
   end

   // ------------------------------------------------------------------
   // Registered buffer write port, valid one cycle after the decision.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf_we    <= 1'b0;
         r_buf_waddr <= '0;
         r_buf_wdata <= '0;
      end else begin
         r_buf_we <= w_write;
         if (w_write) begin
            r_buf_waddr <= r_wr_count[ADDR_W-1:0];
            r_buf_wdata <= r_ad_q;
         end
      end
   end

   assign buf_we    = r_buf_we;
   assign buf_waddr = r_buf_waddr;
   assign buf_wdata = r_buf_wdata;
   assign busy      = w_busy;
   assign done      = w_done;
   assign wr_count  = r_wr_count;

endmodule
`default_nettype wire
